// File: rtl/eth10base_t_rx.sv
// 10BASE-T Manchester receiver: oversampled mid-bit clock recovery, preamble/SFD strip, byte framing, RX LED.
// Optional RX_CRC_CHECK_EN adds rx_crc_ok, the CRC-32 residue verdict reported alongside rx_eof.
module eth10base_t_rx #(
    parameter int OVERSAMPLE   = 8,
    parameter int MIN_PRE_BITS = 16,
    parameter int LED_HOLD     = 8000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_sof,
    output logic       rx_eof,
    output logic       rx_dribble,
`ifdef RX_CRC_CHECK_EN
    output logic       rx_crc_ok,
`endif
    output logic       Led_Rx
);
    localparam int CW = $clog2(3 * OVERSAMPLE / 2 + 1);
    localparam int PW = $clog2(MIN_PRE_BITS + 1);
    localparam int HW = $clog2(LED_HOLD + 1);
    localparam logic [CW-1:0] C_BLANK  = CW'(3 * OVERSAMPLE / 4);
    localparam logic [CW-1:0] C_WIN_HI = CW'(5 * OVERSAMPLE / 4);
    localparam logic [CW-1:0] C_LOSS   = CW'(3 * OVERSAMPLE / 2);
    localparam logic [PW-1:0] C_MINPRE = PW'(MIN_PRE_BITS);

    typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_sync1, r_sync2, r_prev;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_sr;
    logic            r_last;
    logic [PW-1:0]   r_pre_cnt;
    logic [2:0]      r_bit_cnt;
    logic            r_sof;
    logic            r_pend_vld, r_pend_sof, r_pend_eof, r_pend_drib;
    logic [HW-1:0]   r_hold;
    logic            w_edge, w_bit, w_in_win, w_accept, w_loss, w_alt;
    logic [7:0]      w_sr_nxt;
    logic            w_sfd_hit, w_byte_done, w_eof;

    assign w_edge   = r_sync2 ^ r_prev;
    assign w_bit    = r_sync2;
    assign w_in_win = (r_cnt >= C_BLANK) && (r_cnt <= C_WIN_HI);
    assign w_accept = w_edge && ((r_state == IDLE) || w_in_win);
    assign w_loss   = (r_state != IDLE) && (r_cnt == C_LOSS);
    assign w_alt    = (w_bit != r_last);
    assign w_sr_nxt = {w_bit, r_sr[7:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sfd_hit   = 1'b0;
        w_byte_done = 1'b0;
        w_eof       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = PRE;
            end
            PRE: begin
                if (w_loss) begin
                    w_state_nxt = IDLE;
                end else if (w_accept && (r_pre_cnt >= C_MINPRE) && (w_sr_nxt == 8'hD5)) begin
                    w_state_nxt = DATA;
                    w_sfd_hit   = 1'b1;
                end
            end
            DATA: begin
                if (w_loss) begin
                    w_state_nxt = IDLE;
                    w_eof       = 1'b1;
                end else if (w_accept && (r_bit_cnt == 3'd7)) begin
                    w_byte_done = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // r_cnt is the distance in clocks from the last accepted mid-bit edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_prev      <= 1'b0;
            r_cnt       <= '0;
            r_sr        <= '0;
            r_last      <= 1'b0;
            r_pre_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_sof       <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pend_sof  <= 1'b0;
            r_pend_eof  <= 1'b0;
            r_pend_drib <= 1'b0;
        end else begin
            r_sync1    <= Rxd;
            r_sync2    <= r_sync1;
            r_prev     <= r_sync2;
            r_pend_vld <= w_byte_done;
            r_pend_eof <= w_eof;
            if (w_eof) r_pend_drib <= (r_bit_cnt != 3'd0);
            if (w_accept) begin
                r_cnt  <= CW'(1);
                r_last <= w_bit;
                r_sr   <= w_sr_nxt;
                case (r_state)
                    IDLE:    r_pre_cnt <= PW'(1);
                    PRE:     if (!w_alt) r_pre_cnt <= PW'(1);
                             else if (r_pre_cnt != C_MINPRE) r_pre_cnt <= r_pre_cnt + 1'b1;
                    default: r_bit_cnt <= r_bit_cnt + 1'b1;
                endcase
            end else if (r_cnt != C_LOSS) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_sfd_hit) begin
                r_bit_cnt <= '0;
                r_sof     <= 1'b1;
            end
            if (w_byte_done) begin
                r_pend_sof <= r_sof;
                r_sof      <= 1'b0;
            end
            if ((r_state != IDLE) && (w_state_nxt == IDLE)) begin
                r_sr      <= '0;
                r_bit_cnt <= '0;
                r_pre_cnt <= '0;
                r_sof     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_sof     <= 1'b0;
            rx_eof     <= 1'b0;
            rx_dribble <= 1'b0;
            r_hold     <= '0;
            Led_Rx     <= 1'b0;
        end else begin
            rx_valid   <= r_pend_vld;
            rx_data    <= r_pend_vld ? r_sr : 8'h00;
            rx_sof     <= r_pend_vld & r_pend_sof;
            rx_eof     <= r_pend_eof;
            rx_dribble <= r_pend_eof & r_pend_drib;
            if (r_pend_vld || r_pend_eof) r_hold <= HW'(LED_HOLD);
            else if (r_hold != '0) r_hold <= r_hold - 1'b1;
            // w_eof keeps the LED lit across the gap before the eof reload lands
            if ((w_state_nxt != IDLE) || w_eof || r_pend_eof) Led_Rx <= 1'b1;
            else if (r_hold == '0) Led_Rx <= 1'b0;
        end
    end

`ifdef RX_CRC_CHECK_EN
    logic [31:0] r_crc, w_crc_rev;
    logic        r_pend_crc;

    assign w_crc_rev = {<<{r_crc}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc      <= '1;
            r_pend_crc <= 1'b0;
            rx_crc_ok  <= 1'b0;
        end else begin
            if (w_sfd_hit) r_crc <= '1;
            else if ((r_state == DATA) && w_accept)
                r_crc <= {1'b0, r_crc[31:1]} ^ ((r_crc[0] ^ w_bit) ? 32'hEDB88320 : 32'h0);
            r_pend_crc <= w_eof && (r_bit_cnt == 3'd0) && (w_crc_rev == 32'hC704DD7B);
            rx_crc_ok  <= r_pend_crc;
        end
    end
`endif
endmodule

// File: tb/tb_eth10base_t_rx.sv
// Directed bench for eth10base_t_rx: builds Manchester waveforms per clock and checks framing, timing and LED.
module tb_eth10base_t_rx;
    localparam int LH = 200;

    logic       clk = 1'b0;
    logic       rst, Rxd;
    logic [7:0] rx_data;
    logic       rx_valid, rx_sof, rx_eof, rx_dribble, Led_Rx;
`ifdef RX_CRC_CHECK_EN
    logic       rx_crc_ok;
    logic       eof_crc;
    logic [7:0] pl[$];
    logic [31:0] crc, fcs;
`endif

    eth10base_t_rx #(.OVERSAMPLE(8), .MIN_PRE_BITS(16), .LED_HOLD(LH)) dut (
        .clk(clk), .rst(rst), .Rxd(Rxd), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_dribble(rx_dribble),
`ifdef RX_CRC_CHECK_EN
        .rx_crc_ok(rx_crc_ok),
`endif
        .Led_Rx(Led_Rx)
    );

    always #5 clk = ~clk;

    int         total = 0, bad = 0;
    int         cyc = 0;
    logic       bits[$];
    int         offs[$];
    logic       wave[$];
    logic [7:0] exp_dat[$];
    logic [7:0] got_dat[$];
    logic       got_sof[$];
    int         got_vcyc[$];
    int         n_eof, eof_cyc, n_stray = 0;
    logic       eof_drib;
    int         c0, kk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            got_dat.push_back(rx_data);
            got_sof.push_back(rx_sof);
            got_vcyc.push_back(cyc);
        end
        if (rx_eof) begin
            n_eof++;
            eof_drib = rx_dribble;
            eof_cyc  = cyc;
`ifdef RX_CRC_CHECK_EN
            eof_crc  = rx_crc_ok;
`endif
        end
        if ((rx_valid && rx_eof) || (rx_sof && !rx_valid) || (rx_dribble && !rx_eof)) n_stray++;
`ifdef RX_CRC_CHECK_EN
        if (rx_crc_ok && !rx_eof) n_stray++;
`endif
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clr();
        got_dat.delete(); got_sof.delete(); got_vcyc.delete(); exp_dat.delete();
        n_eof = 0; eof_drib = 1'b0; eof_cyc = 0;
    endtask

    task automatic push_bit(input logic b);
        bits.push_back(b);
        offs.push_back(0);
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) push_bit(b[i]);
    endtask

    task automatic new_frame(input int npre, input bit sfd);
        bits.delete(); offs.delete();
        for (int i = 0; i < npre; i++) push_bit(i % 2 == 0);
        if (sfd) add_byte(8'hD5);
    endtask

    function automatic int mid(input int k);
        return 8 * k + 4 + offs[k];
    endfunction

    // Boundary transitions sit halfway between neighbouring mid-bit edges, so jittered bits stay legal.
    task automatic build(input int tail_hi);
        int n, m, s, e;
        n = bits.size();
        wave.delete();
        for (int k = 0; k < n; k++) begin
            m = mid(k);
            s = (k == 0) ? 0 : (mid(k - 1) + m) / 2;
            e = (k == n - 1) ? m + 4 : (m + mid(k + 1)) / 2;
            for (int t = s; t < m; t++) wave.push_back(!bits[k]);
            for (int t = m; t < e; t++) wave.push_back(bits[k]);
        end
        for (int t = 0; t < tail_hi; t++) wave.push_back(1'b1);
        for (int t = 0; t < 40; t++) wave.push_back(1'b0);
    endtask

    task automatic drive(input int upto);
        for (int i = 0; i < upto; i++) begin
            @(posedge clk); #1;
            if (i == 0) c0 = cyc;
            Rxd = wave[i];
        end
    endtask

    task automatic check_bytes(input string tag);
        check({tag, ".count"}, got_dat.size(), exp_dat.size());
        for (int j = 0; j < exp_dat.size() && j < got_dat.size(); j++) begin
            check({tag, ".data"}, got_dat[j], exp_dat[j]);
            check({tag, ".sof"}, got_sof[j], (j == 0));
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".valid"}, rx_valid, 1'b0);
        check({tag, ".data"}, rx_data, 8'h00);
        check({tag, ".sof"}, rx_sof, 1'b0);
        check({tag, ".eof"}, rx_eof, 1'b0);
        check({tag, ".dribble"}, rx_dribble, 1'b0);
        check({tag, ".led"}, Led_Rx, 1'b0);
    endtask

    task automatic nominal_frame();
        clr();
        new_frame(56, 1);
        for (int j = 1; j <= 4; j++) begin
            add_byte(8'(j));
            exp_dat.push_back(8'(j));
        end
        build(24);
        drive(wave.size());
    endtask

    initial begin
        rst = 1'b1;
        Rxd = 1'b0;
        clr();
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b0;
        repeat (20) @(posedge clk);

        // nominal frame, latency and LED
        nominal_frame();
        check_bytes("nominal");
        kk = 56 + 8 + 7;
        check("nominal.lat_first", got_vcyc.size() > 0 ? got_vcyc[0] - c0 : -1, mid(kk) + 4);
        kk = 56 + 8 + 31;
        check("nominal.lat_last", got_vcyc.size() == 4 ? got_vcyc[3] - c0 : -1, mid(kk) + 4);
        check("nominal.eof_cnt", n_eof, 1);
        check("nominal.dribble", eof_drib, 1'b0);
        check("nominal.eof_gap_ge12", got_vcyc.size() == 4 ? (eof_cyc - got_vcyc[3] >= 12) : 0, 1);
        check("nominal.led_on", Led_Rx, 1'b1);
        repeat (LH + 20) @(posedge clk);
        #1;
        check("led_decay", Led_Rx, 1'b0);

        // 8 preamble bits + 7 SFD bits = 15 alternating: rejected
        clr();
        new_frame(8, 1);
        add_byte(8'hAA);
        build(24);
        drive(wave.size());
        check_bytes("short_pre");
        check("short_pre.eof_cnt", n_eof, 0);

        // 10 preamble bits -> 17 alternating: accepted
        clr();
        new_frame(10, 1);
        add_byte(8'h5A);
        exp_dat.push_back(8'h5A);
        build(24);
        drive(wave.size());
        check_bytes("pre10");
        check("pre10.eof_cnt", n_eof, 1);

        // two bytes plus three trailing bits
        clr();
        new_frame(56, 1);
        add_byte(8'hA5); exp_dat.push_back(8'hA5);
        add_byte(8'h3C); exp_dat.push_back(8'h3C);
        push_bit(1'b1); push_bit(1'b0); push_bit(1'b1);
        build(24);
        drive(wave.size());
        check_bytes("dribble");
        check("dribble.eof_cnt", n_eof, 1);
        check("dribble.flag", eof_drib, 1'b1);

        // SFD with no bytes
        clr();
        new_frame(56, 1);
        build(24);
        drive(wave.size());
        check_bytes("empty");
        check("empty.eof_cnt", n_eof, 1);
        check("empty.dribble", eof_drib, 1'b0);

        // NLP link pulse after the LED has expired
        repeat (LH + 20) @(posedge clk);
        clr();
        @(posedge clk); #1 Rxd = 1'b1;
        repeat (8) @(posedge clk);
        #1 Rxd = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("nlp.bytes", got_dat.size(), 0);
        check("nlp.eof_cnt", n_eof, 0);
        check("nlp.led", Led_Rx, 1'b0);

        // 64-byte frame, mid-bit edges at 0,+2,0,-2; idle edge 13 clocks after the last mid-bit edge
        clr();
        new_frame(56, 1);
        for (int j = 0; j < 64; j++) begin
            add_byte(8'(j * 37 + 5));
            exp_dat.push_back(8'(j * 37 + 5));
        end
        for (int k = 0; k < offs.size(); k++) offs[k] = (k % 4 == 1) ? 2 : ((k % 4 == 3) ? -2 : 0);
        build(9);
        drive(wave.size());
        check_bytes("jitter");
        check("jitter.eof_cnt", n_eof, 1);
        check("jitter.dribble", eof_drib, 1'b0);

        // reset after three bytes of a frame
        clr();
        new_frame(56, 1);
        for (int j = 0; j < 6; j++) add_byte(8'(8'h10 + j));
        build(24);
        kk = 56 + 8 + 23;
        drive(mid(kk) + 8);
        check("rstmid.bytes_before", got_dat.size(), 3);
        rst = 1'b1;
        #1;
        check_quiet("rstmid");
        Rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        clr();
        repeat (40) @(posedge clk);
        #1;
        check("rstmid.no_eof", n_eof, 0);
        check("rstmid.no_bytes", got_dat.size(), 0);
        nominal_frame();
        check_bytes("after_rst");
        check("after_rst.eof_cnt", n_eof, 1);

`ifdef RX_CRC_CHECK_EN
        // 60-byte payload with its FCS, then the same FCS over a corrupted payload
        pl.delete();
        for (int i = 0; i < 60; i++) pl.push_back(8'(i * 7 + 1));
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) begin
            crc = crc ^ {24'h0, pl[i]};
            for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        end
        fcs = ~crc;
        for (int i = 0; i < 4; i++) pl.push_back(fcs[8 * i +: 8]);
        for (int pass = 0; pass < 2; pass++) begin
            clr();
            eof_crc = 1'bx;
            if (pass == 1) pl[10] = pl[10] ^ 8'h01;
            new_frame(56, 1);
            for (int i = 0; i < 64; i++) add_byte(pl[i]);
            build(24);
            drive(wave.size());
            check("crc.bytes", got_dat.size(), 64);
            check("crc.eof_cnt", n_eof, 1);
            check("crc.ok", eof_crc, (pass == 0));
        end
`endif

        check("stray_strobes", n_stray, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
